// File: rtl/accel_filter.sv
// accel_filter: moving-average accelerometer filter producing a saturated, deadbanded PWM duty command.
// One sample per four cycles through IDLE -> UPDATE -> SCALE -> OUT.
module accel_filter #(
    parameter int DEPTH    = 8,
    parameter int SHIFT    = 5,
    parameter int DEADBAND = 13
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic        [9:0]  PWMinput,
    output logic               filt_valid,
    output logic               overrange
);
    localparam int LW = $clog2(DEPTH);
    localparam int SW = 16 + LW;

    typedef enum logic [1:0] {IDLE, UPDATE, SCALE, OUT} state_t;

    state_t             state_q, state_d;
    logic signed [15:0] sample_q, sample_d, oldest;
    logic signed [15:0] buf_q [DEPTH];
    logic signed [15:0] buf_d [DEPTH];
    logic [LW-1:0]      wptr_q, wptr_d;
    logic [LW:0]        fill_q, fill_d;
    logic signed [SW-1:0] sum_q, sum_d;
    logic [16:0]        avg, mag, scaled;
    logic [9:0]         cmd_q, cmd_d, sat_cmd, pwm_q, pwm_d;
    logic               ovr_q, ovr_d, ovr_out_q, ovr_out_d, fv_q, fv_d;
    logic               primed, accept, sat;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        accept  = sample_valid && (state_q == IDLE);
        state_d = (state_q == IDLE)   ? (accept ? UPDATE : IDLE) :
                  (state_q == UPDATE) ? SCALE :
                  (state_q == SCALE)  ? OUT : IDLE;
    end

    always_comb begin
        sample_ready = (state_q == IDLE);
        PWMinput     = pwm_q;
        overrange    = ovr_out_q;
        filt_valid   = fv_q;
    end

    // avg keeps 17 bits so that |-32768| = 32768 is representable
    always_comb begin
        primed    = (fill_q == (LW+1)'(DEPTH));
        oldest    = primed ? buf_q[wptr_q] : '0;
        avg       = 17'(sum_q >>> LW);
        mag       = avg[16] ? -avg : avg;
        scaled    = mag >> SHIFT;
        sat       = scaled > 17'd1023;
        sat_cmd   = sat ? 10'd1023 : scaled[9:0];
        sample_d  = accept ? sample_in : sample_q;
        buf_d     = buf_q;
        wptr_d    = wptr_q;
        fill_d    = fill_q;
        sum_d     = sum_q;
        cmd_d     = cmd_q;
        ovr_d     = ovr_q;
        pwm_d     = pwm_q;
        ovr_out_d = ovr_out_q;
        fv_d      = 1'b0;
        if (state_q == UPDATE) begin
            buf_d[wptr_q] = sample_q;
            wptr_d        = wptr_q + 1'b1;
            fill_d        = primed ? fill_q : fill_q + 1'b1;
            sum_d         = sum_q + SW'(sample_q) - SW'(oldest);
        end
        if (state_q == SCALE) begin
            cmd_d = (sat_cmd < 10'(DEADBAND)) ? 10'd0 : sat_cmd;
            ovr_d = sat;
        end
        if (state_q == OUT && primed) begin
            pwm_d     = cmd_q;
            ovr_out_d = ovr_q;
            fv_d      = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sample_q  <= '0;
            wptr_q    <= '0;
            fill_q    <= '0;
            sum_q     <= '0;
            cmd_q     <= '0;
            ovr_q     <= 1'b0;
            pwm_q     <= '0;
            ovr_out_q <= 1'b0;
            fv_q      <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            wptr_q    <= wptr_d;
            fill_q    <= fill_d;
            sum_q     <= sum_d;
            cmd_q     <= cmd_d;
            ovr_q     <= ovr_d;
            pwm_q     <= pwm_d;
            ovr_out_q <= ovr_out_d;
            fv_q      <= fv_d;
        end
    end

    // Stale entries are masked by the fill counter, so the buffer needs no reset
    always_ff @(posedge CLOCK_50) begin
        buf_q <= buf_d;
    end
endmodule
